// File: rtl/sum_seq_pkg.sv
// Shared types and constants for the multi-operand sum sequencer.
// Holds the FSM encoding and the default datapath widths.
package sum_seq_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int CNT_W_DEF  = 4;
    localparam int SUM_W_DEF  = DATA_W_DEF + CNT_W_DEF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Widened sum: holds (2^cnt_w - 1) maximal operands without wrap.
    function automatic int sum_w(input int data_w, input int cnt_w);
        return data_w + cnt_w;
    endfunction

endpackage

// File: rtl/sum_sequencer_if.sv
// Job, operand-stream and result-stream signals of the sum sequencer.
// master drives jobs/operands, slave is the sequencer itself.
interface sum_sequencer_if
    import sum_seq_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) ();

    logic                      start;
    logic [CNT_W-1:0]          num_ops;
    logic                      abort;
    logic [DATA_W-1:0]         in_data;
    logic                      in_valid;
    logic                      in_ready;
    logic [DATA_W+CNT_W-1:0]   out_sum;
    logic                      out_valid;
    logic                      out_ready;
    logic                      busy;

    modport master (
        output start, num_ops, abort,
        output in_data, in_valid, out_ready,
        input  in_ready, out_sum, out_valid, busy
    );

    modport slave (
        input  start, num_ops, abort,
        input  in_data, in_valid, out_ready,
        output in_ready, out_sum, out_valid, busy
    );

endinterface

// File: rtl/sum_accum.sv
// Accumulator register with a zero-extending adder.
// clear wins over en so a new job always starts from zero.
module sum_accum
    import sum_seq_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF,
    parameter int SUM_W  = sum_w(DATA_W, CNT_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              en,
    input  logic [DATA_W-1:0] in_data,
    output logic [SUM_W-1:0]  acc
);

    logic [SUM_W-1:0] addend;

    assign addend = {{(SUM_W-DATA_W){1'b0}}, in_data};

    // Register the running sum; cleared on reset and at job launch.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc + addend;
        end
    end

endmodule

// File: rtl/sum_sequencer.sv
// Sequences a multi-operand accumulation: job start, operand
// stream intake, and a held result until the consumer takes it.
module sum_sequencer
    import sum_seq_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic           clk,
    input  logic           rst,
    sum_sequencer_if.slave bus
);

    localparam int SUM_W = sum_w(DATA_W, CNT_W);

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] remaining;
    logic [SUM_W-1:0] acc;
    logic             launch;
    logic             accept;
    logic             last;

    // abort outranks a start or an accept in the same cycle.
    assign launch = (state == IDLE) && bus.start && !bus.abort;
    assign accept = (state == ACCUM) && bus.in_valid && !bus.abort;
    assign last   = (remaining == CNT_W'(1));

    sum_accum #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W),
        .SUM_W  (SUM_W)
    ) u_accum (
        .clk     (clk),
        .rst     (rst),
        .clear   (launch),
        .en      (accept),
        .in_data (bus.in_data),
        .acc     (acc)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nx = state;
        if (bus.abort) begin
            state_nx = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        state_nx = (bus.num_ops == '0) ? DONE : ACCUM;
                    end
                end
                ACCUM: begin
                    if (bus.in_valid && last) begin
                        state_nx = DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state_nx = IDLE;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    // Operands still owed to the current job.
    always_ff @(posedge clk) begin
        if (rst) begin
            remaining <= '0;
        end else if (launch) begin
            remaining <= bus.num_ops;
        end else if (accept) begin
            remaining <= remaining - CNT_W'(1);
        end
    end

    // Outputs come only from registered state and data.
    always_comb begin
        bus.in_ready  = (state == ACCUM);
        bus.out_valid = (state == DONE);
        bus.busy      = (state != IDLE);
        bus.out_sum   = acc;
    end

endmodule

// File: tb/tb_sum_sequencer.sv
// Directed bench for sum_sequencer with hand-computed results.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_sum_sequencer;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    int   accepts;
    int   gap;
    int   waited;

    sum_sequencer_if #(.DATA_W(8), .CNT_W(4)) bus ();

    sum_sequencer #(.DATA_W(8), .CNT_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input logic [7:0] d);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic idle_chk(input string tag);
        chk({tag, "_rdy"},  32'(bus.in_ready),  32'd0);
        chk({tag, "_ov"},   32'(bus.out_valid), 32'd0);
        chk({tag, "_busy"}, 32'(bus.busy),      32'd0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.num_ops   = '0;
        bus.abort     = 1'b0;
        bus.in_data   = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        idle_chk("por");
        chk("por_sum", 32'(bus.out_sum), 32'h0);
        rst = 1'b0;

        // 1: reset mid-ACCUM after two accepts
        bus.start   = 1'b1;
        bus.num_ops = 4'd4;
        tick();
        bus.start = 1'b0;
        chk("t1_busy", 32'(bus.busy), 32'd1);
        feed(8'h11);
        feed(8'h22);
        chk("t1_part", 32'(bus.out_sum), 32'h033);
        rst = 1'b1;
        tick();
        tick();
        idle_chk("t1_inrst");
        rst = 1'b0;
        tick();
        idle_chk("t1_post");
        chk("t1_sum", 32'(bus.out_sum), 32'h0);

        // 2: three operands back to back
        bus.start   = 1'b1;
        bus.num_ops = 4'd3;
        tick();
        bus.start = 1'b0;
        chk("t2_busy", 32'(bus.busy), 32'd1);
        chk("t2_rdy",  32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h10;
        tick();
        bus.in_data = 8'h20;
        tick();
        chk("t2_ov_early", 32'(bus.out_valid), 32'd0);
        bus.in_data = 8'h30;
        tick();
        bus.in_valid = 1'b0;
        chk("t2_ov",  32'(bus.out_valid), 32'd1);
        chk("t2_sum", 32'(bus.out_sum), 32'h060);
        chk("t2_rdy_done", 32'(bus.in_ready), 32'd0);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        idle_chk("t2_end");

        // 3: fifteen 0xFF operands with random gaps
        bus.start   = 1'b1;
        bus.num_ops = 4'd15;
        tick();
        bus.start = 1'b0;
        accepts = 0;
        for (int i = 0; i < 15; i++) begin
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) tick();
            bus.in_valid = 1'b1;
            bus.in_data  = 8'hFF;
            if (bus.in_ready) accepts++;
            tick();
            bus.in_valid = 1'b0;
        end
        waited = 0;
        while (!bus.out_valid && waited < 4) begin
            tick();
            waited++;
        end
        chk("t3_wait", 32'(waited), 32'd0);
        chk("t3_acc",  32'(accepts), 32'd15);
        chk("t3_ov",   32'(bus.out_valid), 32'd1);
        chk("t3_sum",  32'(bus.out_sum), 32'hEF1);

        // extra operand in DONE must not be taken
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h01;
        chk("t3_rdy_done", 32'(bus.in_ready), 32'd0);

        // 4: stall in DONE with start pulses
        bus.num_ops = 4'd2;
        for (int c = 0; c < 5; c++) begin
            bus.start = (c % 2 == 0);
            tick();
            chk("t4_ov",  32'(bus.out_valid), 32'd1);
            chk("t4_sum", 32'(bus.out_sum), 32'hEF1);
        end
        bus.in_valid  = 1'b0;
        bus.start     = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        bus.start     = 1'b0;
        bus.out_ready = 1'b0;
        idle_chk("t4_end");
        tick();
        idle_chk("t4_stay");

        // 5: zero-operand job
        bus.start   = 1'b1;
        bus.num_ops = 4'd0;
        tick();
        bus.start = 1'b0;
        chk("t5_ov",  32'(bus.out_valid), 32'd1);
        chk("t5_sum", 32'(bus.out_sum), 32'h0);
        chk("t5_rdy", 32'(bus.in_ready), 32'd0);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        idle_chk("t5_end");

        // 6: abort mid-job, then a one-operand job
        bus.start   = 1'b1;
        bus.num_ops = 4'd4;
        tick();
        bus.start = 1'b0;
        feed(8'h40);
        feed(8'h40);
        chk("t6_part", 32'(bus.out_sum), 32'h080);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        idle_chk("t6_abort");
        tick();
        idle_chk("t6_after");
        bus.start   = 1'b1;
        bus.num_ops = 4'd1;
        tick();
        bus.start = 1'b0;
        chk("t6_clr", 32'(bus.out_sum), 32'h0);
        feed(8'h05);
        chk("t6_ov",  32'(bus.out_valid), 32'd1);
        chk("t6_sum", 32'(bus.out_sum), 32'h005);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        idle_chk("t6_end");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
